// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, default widths and latched-command type for mem_arbiter
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 19;
  localparam int MEM_DATA_W = 32;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_WAIT} arb_state_t;
  typedef struct packed {
    logic                  is_rd;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } cmd_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin picker; remembers the last granted index, which loses a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  logic prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev <= 1'b1;
    else if (update) prev <= last;
  assign grant = &req ? ~prev : req[1];
  assign valid = |req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter in front of the SDRAM s2a port.
// Define MEM_ARB_TIMEOUT_EN to build the read-timeout abort and sticky rd_tmo_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int WR_GAP = 4,
  parameter int RD_TMO = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_writeaddr,
  input  logic [DATA_W-1:0] c0_writedata,
  input  logic              c0_read,
  input  logic [ADDR_W-1:0] c0_readaddr,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_readdata,
  output logic              c0_readdone,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_writeaddr,
  input  logic [DATA_W-1:0] c1_writedata,
  input  logic              c1_read,
  input  logic [ADDR_W-1:0] c1_readaddr,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_readdata,
  output logic              c1_readdone,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_writeaddr,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_read,
  output logic [ADDR_W-1:0] m_readaddr,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdone,
  output logic              rd_tmo_err
);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int CNT_MAX = (TMO_EN && RD_TMO > WR_GAP) ? RD_TMO : WR_GAP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  arb_state_t state, state_nx;
  cmd_t cmd;
  logic owner, grant, valid, sel_rd, tmo, rd_end;
  logic [1:0] req, done;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  // A client whose readdone is pulsing still holds its request this cycle; mask it so it is not re-granted.
  assign req = {c1_read | c1_write, c0_read | c0_write} & ~done;
  rr_arb2 u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .update (state == IDLE && valid),
    .last   (grant),
    .grant  (grant),
    .valid  (valid)
  );
  assign sel_rd = grant ? c1_read : c0_read;
  assign sel_addr = grant ? (c1_read ? c1_readaddr : c1_writeaddr) : (c0_read ? c0_readaddr : c0_writeaddr);
  assign sel_data = grant ? c1_writedata : c0_writedata;
  assign tmo = TMO_EN && state == RD_WAIT && !m_readdone && cnt == CNT_W'(RD_TMO - 1);
  assign rd_end = state == RD_WAIT && (m_readdone || tmo);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:                 state_nx = valid ? (sel_rd ? RD_ISSUE : WR_ISSUE) : IDLE;
      WR_ISSUE:             state_nx = mem_arb_pkg::WR_GAP;
      mem_arb_pkg::WR_GAP:  state_nx = cnt == CNT_W'(WR_GAP - 1) ? IDLE : state;
      RD_ISSUE:             state_nx = RD_WAIT;
      RD_WAIT:              state_nx = rd_end ? IDLE : RD_WAIT;
      default:              state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd <= '0;
      owner <= 1'b0;
      cnt <= '0;
      done <= 2'b00;
      c0_readdata <= '0;
      c1_readdata <= '0;
    end else begin
      if (state == IDLE && valid) begin
        owner <= grant;
        cmd <= '{is_rd: sel_rd, addr: MEM_ADDR_W'(sel_addr), data: MEM_DATA_W'(sel_data)};
      end
      cnt <= (state == mem_arb_pkg::WR_GAP || (TMO_EN && state == RD_WAIT)) ? cnt + 1'b1 : '0;
      done <= rd_end ? (owner ? 2'b10 : 2'b01) : 2'b00;
      if (rd_end && !owner) c0_readdata <= m_readdone ? m_readdata : '0;
      if (rd_end && owner) c1_readdata <= m_readdone ? m_readdata : '0;
    end
`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_tmo_err <= 1'b0;
    else if (tmo) rd_tmo_err <= 1'b1;
`else
  assign rd_tmo_err = 1'b0;
`endif
  assign m_write = state == WR_ISSUE && !cmd.is_rd;
  assign m_read = state == RD_ISSUE && cmd.is_rd;
  assign m_writeaddr = ADDR_W'(cmd.addr);
  assign m_readaddr = ADDR_W'(cmd.addr);
  assign m_writedata = DATA_W'(cmd.data);
  assign c0_ack = m_write && !owner;
  assign c1_ack = m_write && owner;
  assign c0_readdone = done[0];
  assign c1_readdone = done[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; expected commands and read returns are queued when driven.
module tb_mem_arbiter;
  localparam int AW = 19, DW = 32, GAP = 4, TMO = 255;
  logic clk = 1'b0, reset_n = 1'b0;
  logic c0_write = 0, c0_read = 0, c1_write = 0, c1_read = 0, m_readdone = 0;
  logic [AW-1:0] c0_writeaddr = '0, c0_readaddr = '0, c1_writeaddr = '0, c1_readaddr = '0;
  logic [DW-1:0] c0_writedata = '0, c1_writedata = '0, m_readdata = '0;
  logic c0_ack, c1_ack, c0_readdone, c1_readdone, m_write, m_read, rd_tmo_err;
  logic [AW-1:0] m_writeaddr, m_readaddr;
  logic [DW-1:0] c0_readdata, c1_readdata, m_writedata;
  typedef struct {bit is_rd; bit owner; logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  exp_t rq[$];
  int checks = 0, failures = 0;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_GAP(GAP), .RD_TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_write(c0_write), .c0_writeaddr(c0_writeaddr), .c0_writedata(c0_writedata),
    .c0_read(c0_read), .c0_readaddr(c0_readaddr), .c0_ack(c0_ack),
    .c0_readdata(c0_readdata), .c0_readdone(c0_readdone),
    .c1_write(c1_write), .c1_writeaddr(c1_writeaddr), .c1_writedata(c1_writedata),
    .c1_read(c1_read), .c1_readaddr(c1_readaddr), .c1_ack(c1_ack),
    .c1_readdata(c1_readdata), .c1_readdone(c1_readdone),
    .m_write(m_write), .m_writeaddr(m_writeaddr), .m_writedata(m_writedata),
    .m_read(m_read), .m_readaddr(m_readaddr), .m_readdata(m_readdata),
    .m_readdone(m_readdone), .rd_tmo_err(rd_tmo_err)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cmd(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (m_write || m_read) begin
        n = i;
        return;
      end
    end
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({m_write, m_read, c0_ack, c1_ack, c0_readdone, c1_readdone, rd_tmo_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=0", {m_write, m_read, c0_ack, c1_ack, c0_readdone, c1_readdone, rd_tmo_err});
    end
    checks++;
    if ({m_writeaddr, m_readaddr, m_writedata} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h/%h want=0", m_writeaddr, m_readaddr, m_writedata);
    end
    checks++;
    if ({c0_readdata, c1_readdata} !== '0) begin
      failures++;
      $display("FAIL reset_readdata got=%h/%h want=0", c0_readdata, c1_readdata);
    end
    reset_n = 1'b1;
    step();
  endtask
  task automatic test_single_write;
    int n;
    exp_t e;
    c0_write = 1; c0_writeaddr = 19'h12345; c0_writedata = 32'hDEADBEEF;
    q.push_back('{0, 0, 19'h12345, 32'hDEADBEEF});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL wr_latency got=%0d want=1", n); end
    checks++;
    if ({m_write, m_read, c0_ack, c1_ack} !== {1'b1, 1'b0, !e.owner, e.owner}) begin
      failures++;
      $display("FAIL wr_strobes got=%b want=%b", {m_write, m_read, c0_ack, c1_ack}, {1'b1, 1'b0, !e.owner, e.owner});
    end
    checks++;
    if ({m_writeaddr, m_writedata} !== {e.addr, e.data}) begin
      failures++;
      $display("FAIL wr_payload got=%h/%h want=%h/%h", m_writeaddr, m_writedata, e.addr, e.data);
    end
    c0_write = 0;
    c1_write = 1; c1_writeaddr = 19'h70F0F; c1_writedata = 32'h01234567;
    q.push_back('{0, 1, 19'h70F0F, 32'h01234567});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (n !== GAP + 2) begin failures++; $display("FAIL wr_gap got=%0d want=%0d", n, GAP + 2); end
    checks++;
    if ({m_write, c0_ack, c1_ack, m_writeaddr, m_writedata} !== {1'b1, !e.owner, e.owner, e.addr, e.data}) begin
      failures++;
      $display("FAIL wr_c1 got=%b%b%b %h/%h want=1%b%b %h/%h", m_write, c0_ack, c1_ack, m_writeaddr, m_writedata,
               !e.owner, e.owner, e.addr, e.data);
    end
    c1_write = 0;
    repeat (GAP + 2) step();
  endtask
  task automatic test_single_read;
    int n;
    exp_t e, r;
    c1_read = 1; c1_readaddr = 19'h00100;
    q.push_back('{1, 1, 19'h00100, '0});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (n !== 1 || {m_read, m_write} !== 2'b10 || m_readaddr !== e.addr) begin
      failures++;
      $display("FAIL rd_issue got=n%0d rw%b addr=%h want=n1 rw10 addr=%h", n, {m_read, m_write}, m_readaddr, e.addr);
    end
    repeat (10) step();
    m_readdone = 1; m_readdata = 32'hCAFEF00D;
    rq.push_back('{1, 1, '0, 32'hCAFEF00D});
    step();
    m_readdone = 0; m_readdata = '1;
    r = rq.pop_front();
    checks++;
    if ({c1_readdone, c0_readdone} !== {r.owner, !r.owner}) begin
      failures++;
      $display("FAIL rd_done got=%b want=%b", {c1_readdone, c0_readdone}, {r.owner, !r.owner});
    end
    checks++;
    if (c1_readdata !== r.data) begin failures++; $display("FAIL rd_data got=%h want=%h", c1_readdata, r.data); end
    c1_read = 0;
    step();
    checks++;
    if ({c1_readdone, c0_readdone} !== 2'b00 || c1_readdata !== r.data) begin
      failures++;
      $display("FAIL rd_pulse_hold got=%b %h want=00 %h", {c1_readdone, c0_readdone}, c1_readdata, r.data);
    end
  endtask
  task automatic test_round_robin;
    int n;
    exp_t e, r;
    c0_readaddr = 19'h00111; c1_readaddr = 19'h00222; c0_read = 1; c1_read = 1;
    for (int i = 0; i < 8; i++) q.push_back('{1, (i % 2) == 1, (i % 2) == 1 ? 19'h00222 : 19'h00111, '0});
    for (int i = 0; i < 8; i++) begin
      wait_cmd(n);
      e = q.pop_front();
      checks++;
      if (n < 0 || m_read !== 1'b1 || m_readaddr !== e.addr) begin
        failures++;
        $display("FAIL rr_grant%0d got=n%0d rd%b addr=%h want addr=%h", i, n, m_read, m_readaddr, e.addr);
      end
      step();
      m_readdone = 1; m_readdata = 32'hA0000000 + DW'(i);
      rq.push_back('{1, e.owner, '0, 32'hA0000000 + DW'(i)});
      step();
      m_readdone = 0; m_readdata = '1;
      r = rq.pop_front();
      if (i == 7) begin c0_read = 0; c1_read = 0; end
      checks++;
      if ({c1_readdone, c0_readdone} !== {r.owner, !r.owner} || (r.owner ? c1_readdata : c0_readdata) !== r.data) begin
        failures++;
        $display("FAIL rr_return%0d got=%b %h want=%b %h", i, {c1_readdone, c0_readdone},
                 r.owner ? c1_readdata : c0_readdata, {r.owner, !r.owner}, r.data);
      end
    end
  endtask
  task automatic test_read_over_write;
    int n;
    exp_t e, r;
    step();
    c0_read = 1; c0_readaddr = 19'h00AAA;
    c0_write = 1; c0_writeaddr = 19'h00BBB; c0_writedata = 32'h5555AAAA;
    q.push_back('{1, 0, 19'h00AAA, '0});
    q.push_back('{0, 0, 19'h00BBB, 32'h5555AAAA});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if ({m_read, m_write, c0_ack} !== 3'b100 || m_readaddr !== e.addr) begin
      failures++;
      $display("FAIL prio_read_first got=%b addr=%h want=100 addr=%h", {m_read, m_write, c0_ack}, m_readaddr, e.addr);
    end
    repeat (3) step();
    m_readdone = 1; m_readdata = 32'h0BADC0DE;
    rq.push_back('{1, 0, '0, 32'h0BADC0DE});
    step();
    m_readdone = 0; m_readdata = '1;
    r = rq.pop_front();
    checks++;
    if ({c0_readdone, c0_ack} !== 2'b10 || c0_readdata !== r.data) begin
      failures++;
      $display("FAIL prio_readdone got=%b %h want=10 %h", {c0_readdone, c0_ack}, c0_readdata, r.data);
    end
    c0_read = 0;
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if ({m_write, m_read, c0_ack} !== 3'b101 || {m_writeaddr, m_writedata} !== {e.addr, e.data}) begin
      failures++;
      $display("FAIL prio_write_after got=%b %h/%h want=101 %h/%h", {m_write, m_read, c0_ack},
               m_writeaddr, m_writedata, e.addr, e.data);
    end
    c0_write = 0;
    repeat (GAP + 2) step();
  endtask
`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    exp_t e;
    c0_read = 1; c0_readaddr = 19'h00777;
    q.push_back('{1, 0, 19'h00777, '0});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (m_read !== 1'b1 || m_readaddr !== e.addr) begin
      failures++;
      $display("FAIL tmo_issue got=%b %h want=1 %h", m_read, m_readaddr, e.addr);
    end
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (c0_readdone) begin n = i; break; end
    end
    checks++;
    if (n !== TMO + 1) begin failures++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); end
    checks++;
    if (c0_readdata !== '0 || rd_tmo_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_abort got=%h err=%b want=0 err=1", c0_readdata, rd_tmo_err);
    end
    c0_read = 0;
    step();
    m_readdone = 1; m_readdata = 32'h11112222;
    step();
    m_readdone = 0;
    step();
    checks++;
    if ({c0_readdone, c1_readdone} !== 2'b00 || rd_tmo_err !== 1'b1 || c0_readdata !== '0) begin
      failures++;
      $display("FAIL tmo_late got=%b err=%b %h want=00 err=1 0", {c0_readdone, c1_readdone}, rd_tmo_err, c0_readdata);
    end
    c1_write = 1; c1_writeaddr = 19'h00444; c1_writedata = 32'h44444444;
    q.push_back('{0, 1, 19'h00444, 32'h44444444});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (n !== 1 || c1_ack !== 1'b1 || m_writeaddr !== e.addr || rd_tmo_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_next got=n%0d ack%b %h err%b want=n1 ack1 %h err1", n, c1_ack, m_writeaddr, rd_tmo_err, e.addr);
    end
    c1_write = 0;
    repeat (GAP + 2) step();
  endtask
`else
  task automatic test_timeout;
    int n;
    exp_t e, r;
    c0_read = 1; c0_readaddr = 19'h00777;
    q.push_back('{1, 0, 19'h00777, '0});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (m_read !== 1'b1 || m_readaddr !== e.addr) begin
      failures++;
      $display("FAIL wait_issue got=%b %h want=1 %h", m_read, m_readaddr, e.addr);
    end
    n = -1;
    for (int i = 1; i <= TMO + 40; i++) begin
      step();
      if (c0_readdone || m_read || m_write) begin n = i; break; end
    end
    checks++;
    if (n !== -1 || rd_tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL wait_forever got=%0d err=%b want=-1 err=0", n, rd_tmo_err);
    end
    m_readdone = 1; m_readdata = 32'h76543210;
    rq.push_back('{1, 0, '0, 32'h76543210});
    step();
    m_readdone = 0; m_readdata = '1;
    r = rq.pop_front();
    c0_read = 0;
    checks++;
    if (c0_readdone !== 1'b1 || c0_readdata !== r.data) begin
      failures++;
      $display("FAIL wait_done got=%b %h want=1 %h", c0_readdone, c0_readdata, r.data);
    end
    step();
  endtask
`endif
  task automatic test_reset_midread;
    int n;
    exp_t e;
    c0_read = 1; c0_readaddr = 19'h00333;
    q.push_back('{1, 0, 19'h00333, '0});
    wait_cmd(n);
    e = q.pop_front();
    checks++;
    if (m_read !== 1'b1 || m_readaddr !== e.addr) begin
      failures++;
      $display("FAIL mid_issue got=%b %h want=1 %h", m_read, m_readaddr, e.addr);
    end
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({m_write, m_read, c0_ack, c1_ack, c0_readdone, c1_readdone, rd_tmo_err, m_writeaddr, m_readaddr, m_writedata,
         c0_readdata, c1_readdata} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset outputs not all zero");
    end
    c0_read = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
    m_readdone = 1; m_readdata = 32'h99999999;
    step();
    m_readdone = 0;
    step();
    checks++;
    if ({c0_readdone, c1_readdone, m_read, m_write} !== 4'b0 || {c0_readdata, c1_readdata} !== '0) begin
      failures++;
      $display("FAIL mid_stray got=%b %h/%h want=0 0/0", {c0_readdone, c1_readdone, m_read, m_write}, c0_readdata, c1_readdata);
    end
    c0_write = 1; c0_writeaddr = 19'h00C0C; c0_writedata = 32'hC0C0C0C0;
    c1_write = 1; c1_writeaddr = 19'h00C1C; c1_writedata = 32'hC1C1C1C1;
    q.push_back('{0, 0, 19'h00C0C, 32'hC0C0C0C0});
    q.push_back('{0, 1, 19'h00C1C, 32'hC1C1C1C1});
    for (int k = 0; k < 2; k++) begin
      wait_cmd(n);
      e = q.pop_front();
      checks++;
      if ({c0_ack, c1_ack} !== {!e.owner, e.owner} || m_writeaddr !== e.addr || m_writedata !== e.data) begin
        failures++;
        $display("FAIL post_reset_rr%0d got=%b %h/%h want=%b %h/%h", k, {c0_ack, c1_ack}, m_writeaddr, m_writedata,
                 {!e.owner, e.owner}, e.addr, e.data);
      end
      if (e.owner) c1_write = 0;
      else c0_write = 0;
    end
    repeat (GAP + 2) step();
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_read_over_write();
    test_timeout();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
